// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, synchronous-read memory between instruction fetch and data access.
// Data wins ties; a bounded data streak forces an instruction grant so fetch cannot starve.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned STREAK_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  state_t              state_q, state_d;
  grant_t              grant_q, grant_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                m_en_q, m_en_d;
  logic [3:0]          m_wen_q, m_wen_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_data_c;

  // Data wins unless fetch is waiting and the data streak has hit its limit.
  assign pick_data_c = d_req && (!i_req || (streak_q < STREAK_MAX));

  // State and output registers; async clear also kills an in-flight write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      streak_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_en_q    <= 1'b0;
      m_wen_q   <= 4'd0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_en_q    <= m_en_d;
      m_wen_q   <= m_wen_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_en_d    = 1'b0;
    m_wen_d   = 4'd0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          m_en_d  = 1'b1;
          state_d = ISSUE;
          if (pick_data_c) begin
            grant_d  = GNT_D;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            m_wen_d  = d_wen;
            streak_d = i_req ? (streak_q + STREAK_W'(1)) : '0;
          end else begin
            grant_d  = GNT_I;
            addr_d   = i_addr;
            streak_d = '0;
          end
        end
      end
      ISSUE: begin
        i_ready_d = (grant_q == GNT_I);
        d_ready_d = (grant_q == GNT_D);
        state_d   = RESP;
      end
      RESP: begin
        if (grant_q == GNT_I) begin
          i_rdata_d = m_rdata;
        end
        if (grant_q == GNT_D) begin
          d_rdata_d = m_rdata;
        end
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  assign m_en    = m_en_q;
  assign m_wen   = m_wen_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;

  // Response data passes straight through during RESP, then holds the captured copy.
  assign i_rdata = ((state_q == RESP) && (grant_q == GNT_I)) ? m_rdata : i_rdata_q;
  assign d_rdata = ((state_q == RESP) && (grant_q == GNT_D)) ? m_rdata : d_rdata_q;

endmodule
